// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, pin widths and
// the one-hot arbiter state encoding.
package sdram_pkg;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 12;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises ref_req every REF_PERIOD cycles once
// running, clears it on grant, and latches ref_overrun if a request is missed.
module sdram_ref_timer #(
    parameter int REF_PERIOD = 1560,
    parameter int CNT_W      = 11
) (
    input  logic sclk,
    input  logic reset,
    input  logic run,
    input  logic grant,
    output logic ref_req,
    output logic ref_overrun
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ref_req_q, ref_req_d;
    logic             ref_overrun_q, ref_overrun_d;
    logic             terminal;

    always_comb begin
        terminal      = run && (cnt_q == CNT_W'(REF_PERIOD - 1));
        cnt_d         = cnt_q;
        ref_req_d     = ref_req_q;
        ref_overrun_d = ref_overrun_q;
        if (run) begin
            cnt_d = terminal ? '0 : cnt_q + 1'b1;
        end
        // A new interval expiring wins over a grant on the same edge.
        if (terminal) begin
            ref_req_d = 1'b1;
        end else if (grant) begin
            ref_req_d = 1'b0;
        end
        if (terminal && ref_req_q) begin
            ref_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            ref_req_q     <= 1'b0;
            ref_overrun_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ref_req_q     <= ref_req_d;
            ref_overrun_q <= ref_overrun_d;
        end
    end

    assign ref_req     = ref_req_q;
    assign ref_overrun = ref_overrun_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter between init, refresh, write and read engines.
// Define SDRAM_ARB_READ_EN to arbitrate the read port; otherwise it is ignored.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = 1560,
    parameter int CNT_W      = 11
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              init_done,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    output logic              ref_req,
    output logic              ref_en,
    input  logic              ref_end,
    input  logic [CMD_W-1:0]  ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_bank,
    input  logic [DQ_W-1:0]   wr_data,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_bank,
    output logic [CMD_W-1:0]  sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              ref_overrun
);

    arb_state_e state_q, state_d;
    logic       ref_en_q, ref_en_d;
    logic       wr_en_q, wr_en_d;
    logic       ref_grant;
`ifdef SDRAM_ARB_READ_EN
    logic       rd_en_q, rd_en_d;
    logic       last_wr_q, last_wr_d;
`else
    logic       unused_rd;
    assign unused_rd = ^{rd_req, rd_end, rd_cmd, rd_addr, rd_bank};
`endif

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD),
        .CNT_W      (CNT_W)
    ) u_ref_timer (
        .sclk        (sclk),
        .reset       (reset),
        .run         (state_q != ST_INIT),
        .grant       (ref_grant),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun)
    );

    always_comb begin
        state_d   = state_q;
        ref_en_d  = 1'b0;
        wr_en_d   = 1'b0;
        ref_grant = 1'b0;
`ifdef SDRAM_ARB_READ_EN
        rd_en_d   = 1'b0;
        last_wr_d = last_wr_q;
`endif
        case (state_q)
            ST_INIT: begin
                if (init_done) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (ref_req) begin
                    state_d   = ST_AREF;
                    ref_en_d  = 1'b1;
                    ref_grant = 1'b1;
`ifdef SDRAM_ARB_READ_EN
                // On a tie, serve whichever of write/read was not served last.
                end else if (wr_req && (!rd_req || !last_wr_q)) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    last_wr_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = ST_READ;
                    rd_en_d   = 1'b1;
                    last_wr_d = 1'b0;
                end
`else
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                end
`endif
            end
            ST_AREF: begin
                if (ref_end) state_d = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end) state_d = ST_ARBIT;
            end
`ifdef SDRAM_ARB_READ_EN
            ST_READ: begin
                if (rd_end) state_d = ST_ARBIT;
            end
`endif
            default: state_d = ST_ARBIT;
        endcase
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
`ifdef SDRAM_ARB_READ_EN
            rd_en_q   <= 1'b0;
            last_wr_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ref_en_q  <= ref_en_d;
            wr_en_q   <= wr_en_d;
`ifdef SDRAM_ARB_READ_EN
            rd_en_q   <= rd_en_d;
            last_wr_q <= last_wr_d;
`endif
        end
    end

    assign ref_en = ref_en_q;
    assign wr_en  = wr_en_q;
`ifdef SDRAM_ARB_READ_EN
    assign rd_en  = rd_en_q;
`else
    assign rd_en  = 1'b0;
`endif

    // Pin mux is purely a function of the registered state.
    always_comb begin
        sdram_cmd    = CMD_NOP;
        sdram_addr   = '0;
        sdram_ba     = '0;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_WRITE: begin
                sdram_cmd    = wr_cmd;
                sdram_addr   = wr_addr;
                sdram_ba     = wr_bank;
                sdram_dq_out = wr_data;
                sdram_dq_oe  = 1'b1;
            end
`ifdef SDRAM_ARB_READ_EN
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_bank;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init, write grant, refresh during write,
// overrun, write/read alternation and asynchronous reset mid-operation.
module tb_sdram_arbit;

    logic        sclk = 1'b0;
    logic        reset;
    logic        init_done;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        ref_req, ref_en, ref_end;
    logic [3:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic        wr_req, wr_en, wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic [15:0] wr_data;
    logic        rd_req, rd_en, rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        ref_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int since_arb = 0;
    bit armed = 1'b0;

    localparam logic [3:0] NOP = 4'b0111;

    always #5 sclk = ~sclk;

    sdram_arbit dut (
        .sclk(sclk), .reset(reset), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .ref_en(ref_en), .ref_end(ref_end),
        .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .ref_overrun(ref_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
        if (armed) since_arb++;
    endtask

    task automatic enter_arbit();
        init_done = 1'b1;
        tick();
        armed     = 1'b1;
        since_arb = 0;
        init_done = 1'b0;
    endtask

    initial begin
        reset = 1'b0; init_done = 1'b0;
        init_cmd = 4'b0010; init_addr = 12'h400;
        ref_end = 1'b0; ref_cmd = 4'b0001; ref_addr = 12'h0A5;
        wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_addr = 12'h123;
        wr_bank = 2'd2; wr_data = 16'hBEEF;
        rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_addr = 12'h456; rd_bank = 2'd1;

        repeat (2) tick();
        check("rst_cmd", sdram_cmd, init_cmd);
        check("rst_addr", sdram_addr, init_addr);
        check("rst_ba", sdram_ba, 0);
        check("rst_oe", sdram_dq_oe, 0);
        check("rst_en", {ref_en, wr_en, rd_en}, 0);
        check("rst_req", {ref_req, ref_overrun}, 0);
        reset = 1'b1;
        repeat (9) tick();
        check("init_hold", sdram_cmd, init_cmd);

        enter_arbit();
        check("arb_nop", sdram_cmd, NOP);
        check("arb_addr", {sdram_addr, sdram_ba}, 0);
        check("arb_dq", {sdram_dq_oe, sdram_dq_out}, 0);
        tick();
        check("init_drop_ignored", sdram_cmd, NOP);

        // Plain write grant, foreign ref_end ignored, release to NOP.
        wr_req = 1'b1;
        tick();
        check("wr_en_pulse", wr_en, 1);
        check("wr_cmd", sdram_cmd, wr_cmd);
        check("wr_addr_ba", {sdram_addr, sdram_ba}, {wr_addr, wr_bank});
        check("wr_dq", {sdram_dq_oe, sdram_dq_out}, {1'b1, wr_data});
        wr_req = 1'b0; ref_end = 1'b1;
        tick();
        check("wr_en_one_cycle", wr_en, 0);
        check("ref_end_ignored", sdram_dq_oe, 1);
        ref_end = 1'b0; wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check("wr_release_nop", sdram_cmd, NOP);
        check("wr_release_oe", sdram_dq_oe, 0);

        // Timer expiry while WRITE holds the bus.
        while (since_arb < 1549) tick();
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        check("wr2_en", wr_en, 1);
        while (since_arb < 1559) tick();
        check("ref_req_early", ref_req, 0);
        tick();
        check("ref_req_rise", ref_req, 1);
        check("wr_not_preempted", {sdram_dq_oe, ref_en}, 2'b10);
        wr_req = 1'b1; wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check("post_wr_nop", sdram_cmd, NOP);
        check("ref_req_held", ref_req, 1);
        tick();
        wr_req = 1'b0;
        check("ref_beats_wr", {ref_en, wr_en}, 2'b10);
        check("ref_req_clear", ref_req, 0);
        check("aref_cmd", {sdram_cmd, sdram_addr}, {ref_cmd, ref_addr});
        tick();
        check("ref_en_one_cycle", ref_en, 0);

        // Refresh engine stalls: second pending interval flags overrun.
        while (since_arb < 3120) tick();
        check("ref_req_2nd", {ref_req, ref_overrun}, 2'b10);
        while (since_arb < 4679) tick();
        check("overrun_early", ref_overrun, 0);
        tick();
        check("overrun_set", ref_overrun, 1);
        ref_end = 1'b1;
        tick();
        ref_end = 1'b0;
        check("aref_release_nop", sdram_cmd, NOP);
        tick();
        check("ref_regrant", {ref_en, ref_req}, 2'b10);
        check("overrun_sticky", ref_overrun, 1);
        ref_end = 1'b1;
        tick();
        ref_end = 1'b0;
        reset = 1'b0;
        #1;
        check("overrun_reset", {ref_overrun, ref_req}, 0);
        check("reset_cmd", sdram_cmd, init_cmd);
        tick();
        reset = 1'b1;
        armed = 1'b0;
        enter_arbit();

        // Both requesters held: grant sequence alternates when reads exist.
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_w;
`ifdef SDRAM_ARB_READ_EN
            exp_w = (i % 2 == 0);
`else
            exp_w = 1'b1;
`endif
            tick();
            check($sformatf("alt%0d_grant", i), {wr_en, rd_en}, {exp_w, ~exp_w});
            check($sformatf("alt%0d_cmd", i), sdram_cmd, exp_w ? wr_cmd : rd_cmd);
            wr_end = exp_w; rd_end = ~exp_w;
            tick();
            wr_end = 1'b0; rd_end = 1'b0;
            check($sformatf("alt%0d_nop", i), {sdram_cmd, wr_en, rd_en}, {NOP, 2'b00});
        end

        // Asynchronous reset while an engine owns the bus.
`ifdef SDRAM_ARB_READ_EN
        wr_req = 1'b0;
        tick();
        rd_req = 1'b0;
        check("rd_owned", {sdram_cmd, rd_en}, {rd_cmd, 1'b1});
`else
        rd_req = 1'b0;
        tick();
        wr_req = 1'b0;
        check("wr_owned", {sdram_cmd, wr_en}, {wr_cmd, 1'b1});
`endif
        reset = 1'b0;
        #1;
        check("mid_reset_cmd", sdram_cmd, init_cmd);
        check("mid_reset_en", {ref_en, wr_en, rd_en}, 0);
        check("mid_reset_oe", sdram_dq_oe, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command-bus arbiter for the single-bank SDRAM controller. Owns the SDRAM command/address/bank/data pins and time-shares them between the init sequencer, the auto-refresh engine, the write engine and the read engine. Contains the refresh interval timer that raises `ref_req`. Grants are issued with a one-cycle `*_en` handshake; ownership is released with a one-cycle `*_end` pulse.

## Interface
- `REF_PERIOD`, 1560: sclk cycles between refresh requests (15.6 µs at 100 MHz).
- `CNT_W`, 11: refresh counter width; must satisfy 2^CNT_W > REF_PERIOD.
- `sclk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `init_done`  in  1  init sequencer finished, level.
- `init_cmd`  in  4 / `init_addr`  in  12  init sequencer command/address.
- `ref_req`  out  1  refresh pending; also routed to write/read engines.
- `ref_en`  out  1  refresh grant pulse.
- `ref_end`  in  1  refresh engine done pulse.
- `ref_cmd`  in  4 / `ref_addr`  in  12.
- `wr_req`  in  1 / `wr_en`  out  1 / `wr_end`  in  1  write handshake.
- `wr_cmd`  in  4 / `wr_addr`  in  12 / `wr_bank`  in  2 / `wr_data`  in  16.
- `rd_req`  in  1 / `rd_en`  out  1 / `rd_end`  in  1  read handshake.
- `rd_cmd`  in  4 / `rd_addr`  in  12 / `rd_bank`  in  2.
- `sdram_cmd`  out  4  {cs_n, ras_n, cas_n, we_n}.
- `sdram_addr`  out  12 / `sdram_ba`  out  2.
- `sdram_dq_out`  out  16 / `sdram_dq_oe`  out  1.
- `ref_overrun`  out  1  sticky: refresh interval expired while `ref_req` still pending.

## Operation
- One-hot states: INIT, ARBIT, AREF, WRITE, READ.
- INIT: pins driven from `init_*`. `init_done`=1 → ARBIT. Later deassertion of `init_done` is ignored.
- ARBIT: pins driven NOP (4'b0111), addr 0, ba 0. Priority: `ref_req` > write/read. Write vs read when both requested: serve the one not served last (`last_wr` flag, reset 0 → write wins first tie). Single requester served directly.
- AREF/WRITE/READ: pins muxed from the granted engine. Return to ARBIT on that engine's `*_end`. `*_end` from a non-owning engine is ignored.
- `sdram_dq_out` = `wr_data`, `sdram_dq_oe` = 1 only in WRITE; otherwise dq_out 0, oe 0.
- Refresh timer: counts only after leaving INIT; 0..REF_PERIOD-1, wraps. At terminal count sets `ref_req`. `ref_req` cleared on the edge that issues `ref_en`. Terminal count with `ref_req` already 1 → `ref_overrun` set; cleared only by reset.
- Engines holding the bus watch `ref_req` and terminate early; arbiter does not preempt.

## Timing
- Reset values: state INIT, all `*_en` 0, `ref_req` 0, `ref_overrun` 0, counter 0, `last_wr` 0; pin outputs follow INIT mux (init_cmd/init_addr, ba 0, oe 0).
- Pin mux combinational from registered state; no added latency.
- Grant: edge N samples requests in ARBIT → state moves to granted state and `*_en`=1 for exactly the cycle following edge N. `*_en` never asserted outside that one cycle.
- Release: `*_end` sampled at edge M → ARBIT from M; at least one NOP cycle before next grant.
- `ref_req` rising and `wr_req` in same ARBIT cycle → AREF.
- `*_end` coincident with refresh terminal count → ARBIT, then AREF next edge.
- Reset mid-operation: immediate return to INIT, all grants dropped.

## Configuration
- `SDRAM_ARB_READ_EN` defined: read port arbitrated as above.
- Undefined: READ state and `last_wr` removed; `rd_req`/`rd_end`/`rd_*` inputs ignored; `rd_en` tied 0; write served whenever no refresh pending.

## Structure
- Shared package `sdram_pkg`: CMD_NOP/PRE/AREF/ACT/WR/RD encodings, state one-hot constants, address/bank/data widths.
- Sub-module `sdram_ref_timer`: interval counter, `ref_req` set/clear, `ref_overrun`.

## Test plan
- Reset, `init_done`=1 at cycle 10 → ARBIT at 11; pins NOP; no `ref_req` before cycle 11+1560.
- `wr_req` held in ARBIT → `wr_en` one-cycle pulse, `sdram_cmd`=`wr_cmd`, `sdram_dq_oe`=1 until `wr_end`, then NOP cycle.
- Timer expiry while WRITE active → `ref_req`=1 held; after `wr_end`, ARBIT then AREF with `ref_en` pulse, `ref_req` cleared same edge.
- `wr_req` and `rd_req` both held continuously → grants alternate W,R,W,R (with `SDRAM_ARB_READ_EN`); without macro only `wr_en`.
- Hold `ref_end` low past 2×1560 cycles → `ref_overrun`=1, sticky until reset.
- Assert reset during READ → state INIT, `rd_en` 0, `sdram_cmd`=`init_cmd` immediately.
